reg_exec_sequencer: RTL

- Multi-cycle instruction sequencer directly upstream of the 4x16-bit register file (1 combinational read port, 1 synchronous write port).
- Accepts 16-bit instructions over a valid/ready handshake, reads operands one per cycle through the single read port, computes the result, and issues one write-back per instruction.
- Drives the register file's read index, write index, write enable and write data; consumes its read data.

---
 rtl/reg_exec_pkg.sv | 43 ++++
 rtl/reg_exec_sequencer_if.sv | 27 ++
 rtl/exec_alu.sv | 35 +++
 rtl/reg_exec_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_exec_pkg.sv
// Shared types for the register-file execution sequencer: opcodes, FSM states
// and instruction field positions.
package reg_exec_pkg;

    localparam int INSTR_WIDTH   = 16;
    localparam int IMM_WIDTH     = 8;
    localparam int RETIRED_WIDTH = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_MOV  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_ADDI = 4'd5,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD1    = 3'd1,
        S_RD2    = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    // True for the opcodes whose write-back also updates the carry flag.
    function automatic logic op_sets_carry(input logic [3:0] op);
        logic sets_s;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI: sets_s = 1'b1;
            default:                 sets_s = 1'b0;
        endcase
        return sets_s;
    endfunction

endpackage

// File: rtl/reg_exec_sequencer_if.sv
// Instruction handshake plus register-file port bundle; master is the
// sequencer side, slave is the instruction source / register file side.
interface reg_exec_sequencer_if
    import reg_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [IDX_WIDTH-1:0]   rf_read_index;
    logic [DATA_WIDTH-1:0]  rf_read_data;
    logic [IDX_WIDTH-1:0]   rf_write_index;
    logic                   rf_write_enable;
    logic [DATA_WIDTH-1:0]  rf_write_data;

    modport master (
        input  instr_valid, instr, rf_read_data,
        output instr_ready, rf_read_index, rf_write_index, rf_write_enable, rf_write_data
    );

    modport slave (
        output instr_valid, instr, rf_read_data,
        input  instr_ready, rf_read_index, rf_write_index, rf_write_enable, rf_write_data
    );
endinterface

// File: rtl/exec_alu.sv
// Combinational datapath: one (DATA_WIDTH+1)-bit sum whose top bit is the
// carry (ADD/ADDI) or borrow (SUB).
module exec_alu
    import reg_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [IMM_WIDTH-1:0]  imm,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);
    logic [DATA_WIDTH:0] sum_s;
    logic [DATA_WIDTH:0] imm_ext_s;

    assign imm_ext_s = {{(DATA_WIDTH + 1 - IMM_WIDTH){1'b0}}, imm};

    // Operation select; op_b is the destination operand for ADD/SUB
    always_comb begin
        sum_s = {(DATA_WIDTH + 1){1'b0}};
        case (op)
            OP_LDI:  sum_s = imm_ext_s;
            OP_MOV:  sum_s = {1'b0, op_a};
            OP_ADD:  sum_s = {1'b0, op_b} + {1'b0, op_a};
            OP_SUB:  sum_s = {1'b0, op_b} - {1'b0, op_a};
            OP_ADDI: sum_s = {1'b0, op_a} + imm_ext_s;
            default: sum_s = {(DATA_WIDTH + 1){1'b0}};
        endcase
    end

    assign result = sum_s[DATA_WIDTH-1:0];
    assign carry  = sum_s[DATA_WIDTH];
endmodule

// File: rtl/reg_exec_sequencer.sv
// Multi-cycle sequencer in front of a 4-entry register file: one operand read
// per cycle, one write-back per instruction, no overlap between instructions.
module reg_exec_sequencer
    import reg_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    reg_exec_sequencer_if.master     bus,
    output logic                     busy,
    output logic                     halted,
    output logic                     carry,
    output logic                     zero,
    output logic                     err_illegal,
    output logic [RETIRED_WIDTH-1:0] retired
);
    state_e                   state_r;
    state_e                   state_next_s;
    logic [INSTR_WIDTH-1:0]   ir_r;
    logic [INSTR_WIDTH-1:0]   cur_instr_s;
    logic [3:0]               op_s;
    logic [IDX_WIDTH-1:0]     rd_s;
    logic [IDX_WIDTH-1:0]     rs_s;
    logic [IMM_WIDTH-1:0]     imm_s;
    logic [IDX_WIDTH-1:0]     read_idx_next_s;
    logic [IDX_WIDTH-1:0]     read_idx_r;
    logic [IDX_WIDTH-1:0]     wr_idx_r;
    logic [DATA_WIDTH-1:0]    opa_r;
    logic [DATA_WIDTH-1:0]    opb_r;
    logic [DATA_WIDTH-1:0]    alu_a_s;
    logic [DATA_WIDTH-1:0]    alu_b_s;
    logic [DATA_WIDTH-1:0]    alu_result_s;
    logic [DATA_WIDTH-1:0]    wr_data_r;
    logic                     alu_carry_s;
    logic                     wb_carry_r;
    logic                     wr_en_r;
    logic                     accept_s;
    logic                     retire_s;
    logic                     illegal_s;
    logic                     enter_wb_s;
    logic                     carry_r;
    logic                     zero_r;
    logic                     err_r;
    logic [RETIRED_WIDTH-1:0] retired_r;

    assign bus.instr_ready = (state_r == S_IDLE) && !reset;
    assign accept_s        = bus.instr_valid && bus.instr_ready;

    // In IDLE the fields decode straight from the bus so the accept edge can
    // already pick the next state and, for LDI, the write-back value.
    assign cur_instr_s = (state_r == S_IDLE) ? bus.instr : ir_r;
    assign op_s        = cur_instr_s[OP_MSB:OP_LSB];
    assign rd_s        = cur_instr_s[RD_LSB +: IDX_WIDTH];
    assign rs_s        = cur_instr_s[RS_LSB +: IDX_WIDTH];
    assign imm_s       = cur_instr_s[IMM_LSB +: IMM_WIDTH];
    assign enter_wb_s  = (state_next_s == S_WB);

    assign alu_a_s = (state_r == S_RD1) ? bus.rf_read_data : opa_r;
    assign alu_b_s = (state_r == S_RD2) ? bus.rf_read_data : opb_r;

    exec_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op     (op_s),
        .op_a   (alu_a_s),
        .op_b   (alu_b_s),
        .imm    (imm_s),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // Next-state decode plus retire / illegal events
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (op_s)
                        OP_NOP:                          retire_s     = 1'b1;
                        OP_LDI:                          state_next_s = S_WB;
                        OP_MOV, OP_ADDI, OP_ADD, OP_SUB: state_next_s = S_RD1;
                        OP_HALT: begin
                            state_next_s = S_HALTED;
                            retire_s     = 1'b1;
                        end
                        default:                         illegal_s    = 1'b1;
                    endcase
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RD1: begin
                if ((op_s == OP_ADD) || (op_s == OP_SUB)) begin
                    state_next_s = S_RD2;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_RD2:    state_next_s = S_WB;
            S_WB: begin
                state_next_s = S_IDLE;
                retire_s     = 1'b1;
            end
            S_HALTED: state_next_s = S_HALTED;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Read index for the coming state: source first, destination second
    always_comb begin
        read_idx_next_s = {IDX_WIDTH{1'b0}};
        if (state_next_s == S_RD1) begin
            if (op_s == OP_ADDI) begin
                read_idx_next_s = rd_s;
            end else begin
                read_idx_next_s = rs_s;
            end
        end else if (state_next_s == S_RD2) begin
            read_idx_next_s = rd_s;
        end else begin
            read_idx_next_s = {IDX_WIDTH{1'b0}};
        end
    end

    // State register and instruction latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            ir_r    <= {INSTR_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                ir_r <= bus.instr;
            end
        end
    end

    // Operand capture from the combinational read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_r <= {DATA_WIDTH{1'b0}};
            opb_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (state_r == S_RD1) begin
                opa_r <= bus.rf_read_data;
            end
            if (state_r == S_RD2) begin
                opb_r <= bus.rf_read_data;
            end
        end
    end

    // Register-file drive, registered one edge ahead of the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_idx_r <= {IDX_WIDTH{1'b0}};
            wr_en_r    <= 1'b0;
            wr_idx_r   <= {IDX_WIDTH{1'b0}};
            wr_data_r  <= {DATA_WIDTH{1'b0}};
            wb_carry_r <= 1'b0;
        end else begin
            read_idx_r <= read_idx_next_s;
            wr_en_r    <= enter_wb_s;
            wr_idx_r   <= enter_wb_s ? rd_s : {IDX_WIDTH{1'b0}};
            wr_data_r  <= enter_wb_s ? alu_result_s : {DATA_WIDTH{1'b0}};
            wb_carry_r <= enter_wb_s ? alu_carry_s : 1'b0;
        end
    end

    // Status flags and the retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
            err_r     <= 1'b0;
            retired_r <= {RETIRED_WIDTH{1'b0}};
        end else begin
            if (state_r == S_WB) begin
                zero_r <= (wr_data_r == {DATA_WIDTH{1'b0}});
                if (op_sets_carry(op_s)) begin
                    carry_r <= wb_carry_r;
                end
            end
            if (illegal_s) begin
                err_r <= 1'b1;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(RETIRED_WIDTH - 1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.rf_read_index   = read_idx_r;
    assign bus.rf_write_enable = wr_en_r;
    assign bus.rf_write_index  = wr_idx_r;
    assign bus.rf_write_data   = wr_data_r;
    assign busy                = (state_r != S_IDLE);
    assign halted              = (state_r == S_HALTED);
    assign carry               = carry_r;
    assign zero                = zero_r;
    assign err_illegal         = err_r;
    assign retired             = retired_r;
endmodule
